// File: rtl/simd_alu_pipe.sv
// Pipelined LANES-wide signed ADD/SUB/MUL/MAC ALU with a global valid/ready stall.
// Optional per-lane sticky MAC overflow flags: define SIMD_ALU_OVF_FLAG_EN.

module simd_alu_lane #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               fire,
  input  logic [1:0]         op,
  input  logic               clr,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] r
`ifdef SIMD_ALU_OVF_FLAG_EN
  , output logic             ovf
`endif
);
  localparam logic [1:0] OP_ADD = 2'b00, OP_MUL = 2'b01, OP_SUB = 2'b10, OP_MAC = 2'b11;

  logic signed [2*WIDTH-1:0] ae, be, prod, base, acc_q;

  assign ae   = {{WIDTH{a[WIDTH-1]}}, a};
  assign be   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod = ae * be;
  assign base = clr ? '0 : acc_q;

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:  r = ae + be;
      OP_MUL:  r = prod;
      OP_SUB:  r = ae - be;
      default: r = base + prod;
    endcase
  end

  // Accumulator lives in the final stage so consecutive MACs see each other with no forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  acc_q <= '0;
    else if (en && fire) begin
      if (op == OP_MAC)       acc_q <= r;
      else if (clr)           acc_q <= '0;
    end
  end

`ifdef SIMD_ALU_OVF_FLAG_EN
  logic ovf_q, ov_now;
  assign ov_now = (base[2*WIDTH-1] == prod[2*WIDTH-1]) && (r[2*WIDTH-1] != base[2*WIDTH-1]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             ovf_q <= 1'b0;
    else if (en && fire) begin
      if (clr)                           ovf_q <= 1'b0;
      else if (op == OP_MAC && ov_now)   ovf_q <= 1'b1;
    end
  end
  assign ovf = ovf_q;
`endif
endmodule

module simd_alu_pipe #(
  parameter int LANES = 16,
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic                   acc_clr,
  input  logic [LANES*WIDTH-1:0] a_flat,
  input  logic [LANES*WIDTH-1:0] b_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] lo_flat,
  output logic [LANES*WIDTH-1:0] hi_flat
`ifdef SIMD_ALU_OVF_FLAG_EN
  , output logic [LANES-1:0]     ovf
`endif
);
  logic en;
  logic out_valid_q;
  logic [LANES-1:0][WIDTH-1:0]   lo_q, hi_q;
  logic [LANES-1:0][2*WIDTH-1:0] lane_r;

  // Final-stage operands: straight from the inputs when LAT=1, else from the carry registers.
  logic                          f_vld, f_clr;
  logic [1:0]                    f_op;
  logic [LANES-1:0][WIDTH-1:0]   f_a, f_b;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign lo_flat   = lo_q;
  assign hi_flat   = hi_q;

  if (LAT == 1) begin : g_direct
    assign f_vld = in_valid;
    assign f_op  = op;
    assign f_clr = acc_clr;
    assign f_a   = a_flat;
    assign f_b   = b_flat;
  end else begin : g_pipe
    logic [LAT-2:0]         vld_pipe, clr_q;
    logic [1:0]             op_q [LAT-1];
    logic [LANES*WIDTH-1:0] a_q  [LAT-1];
    logic [LANES*WIDTH-1:0] b_q  [LAT-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe <= '0;
        clr_q    <= '0;
        for (int s = 0; s < LAT-1; s++) begin
          op_q[s] <= '0;
          a_q[s]  <= '0;
          b_q[s]  <= '0;
        end
      end else if (en) begin
        vld_pipe[0] <= in_valid;
        clr_q[0]    <= acc_clr;
        op_q[0]     <= op;
        a_q[0]      <= a_flat;
        b_q[0]      <= b_flat;
        for (int s = 1; s < LAT-1; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          clr_q[s]    <= clr_q[s-1];
          op_q[s]     <= op_q[s-1];
          a_q[s]      <= a_q[s-1];
          b_q[s]      <= b_q[s-1];
        end
      end
    end

    assign f_vld = vld_pipe[LAT-2];
    assign f_clr = clr_q[LAT-2];
    assign f_op  = op_q[LAT-2];
    assign f_a   = a_q[LAT-2];
    assign f_b   = b_q[LAT-2];
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_alu_lane #(.WIDTH(WIDTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .fire (f_vld),
      .op   (f_op),
      .clr  (f_clr),
      .a    (f_a[i]),
      .b    (f_b[i]),
      .r    (lane_r[i])
`ifdef SIMD_ALU_OVF_FLAG_EN
      , .ovf(ovf[i])
`endif
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
    end else if (en) begin
      out_valid_q <= f_vld;
      if (f_vld) begin
        for (int i = 0; i < LANES; i++) begin
          lo_q[i] <= lane_r[i][WIDTH-1:0];
          hi_q[i] <= lane_r[i][2*WIDTH-1:WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench for simd_alu_pipe: directed lane-0 vectors, other lanes checked against a reference model.
module tb_simd_alu_pipe;
  localparam int LANES = 16, WIDTH = 32, LAT = 2;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, acc_clr, out_valid, out_ready;
  logic [1:0] op;
  logic [LANES*WIDTH-1:0] a_flat, b_flat, lo_flat, hi_flat;
`ifdef SIMD_ALU_OVF_FLAG_EN
  logic [LANES-1:0] ovf;
`endif

  simd_alu_pipe #(.LANES(LANES), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc_clr(acc_clr), .a_flat(a_flat), .b_flat(b_flat), .out_valid(out_valid),
    .out_ready(out_ready), .lo_flat(lo_flat),
`ifdef SIMD_ALU_OVF_FLAG_EN
    .ovf(ovf),
`endif
    .hi_flat(hi_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0][63:0] r;
    logic [LANES-1:0]       ovf;
    bit                     hand_en;
    logic [63:0]            hand;
    bit                     lat_en;
    int                     acc_cyc;
    string                  name;
  } exp_t;

  exp_t   sb[$];
  longint acc_m[LANES];
  bit     ovf_m[LANES];
  int     n_chk = 0, n_pass = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic logic [63:0] model(input int i, input logic [1:0] o, input bit c,
                                        input logic [31:0] a, input logic [31:0] b);
    longint ae, be, prod, base, r;
    ae   = longint'($signed(a));
    be   = longint'($signed(b));
    prod = ae * be;
    base = c ? 64'sd0 : acc_m[i];
    case (o)
      2'b00:   r = ae + be;
      2'b01:   r = prod;
      2'b10:   r = ae - be;
      default: r = base + prod;
    endcase
    if (c) ovf_m[i] = 1'b0;
    if (o == 2'b11) begin
      if (!c && (base[63] == prod[63]) && (r[63] != base[63])) ovf_m[i] = 1'b1;
      acc_m[i] = r;
    end else if (c) acc_m[i] = 0;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [1:0] o, input bit c, input logic [31:0] a0, input logic [31:0] b0,
                      input bit he, input logic [63:0] hv, input bit le, input string nm);
    exp_t e;
    int   waited;
    op = o; acc_clr = c;
    a_flat[31:0] = a0; b_flat[31:0] = b0;
    for (int i = 1; i < LANES; i++) begin
      a_flat[i*WIDTH +: WIDTH] = $urandom;
      b_flat[i*WIDTH +: WIDTH] = $urandom;
    end
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check(1'b0, "accept_timeout", $sformatf("%s in_ready=%0b want 1", nm, in_ready));
      in_valid = 1'b0;
      return;
    end
    e.acc_cyc = cyc;
    for (int i = 0; i < LANES; i++) begin
      e.r[i]   = model(i, o, c, a_flat[i*WIDTH +: WIDTH], b_flat[i*WIDTH +: WIDTH]);
      e.ovf[i] = ovf_m[i];
    end
    e.hand_en = he; e.hand = hv; e.lat_en = le; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    check(sb.size() == 0, "drain", $sformatf("pending=%0d want 0", sb.size()));
  endtask

  // Monitor: one pop per handoff, sampled mid-cycle.
  initial begin
    exp_t e;
    int   bad;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_out", $sformatf("lo0=%h hi0=%h want no output", lo_flat[31:0], hi_flat[31:0]));
        end else begin
          e = sb.pop_front();
          bad = -1;
          for (int i = LANES-1; i >= 0; i--)
            if ({hi_flat[i*WIDTH +: WIDTH], lo_flat[i*WIDTH +: WIDTH]} !== e.r[i]) bad = i;
          if (bad < 0) bad = LANES;
          check(bad == LANES, {e.name, "_model"}, $sformatf("lane %0d got %h want %h", bad % LANES,
                {hi_flat[(bad % LANES)*WIDTH +: WIDTH], lo_flat[(bad % LANES)*WIDTH +: WIDTH]}, e.r[bad % LANES]));
          if (e.hand_en)
            check({hi_flat[31:0], lo_flat[31:0]} === e.hand, e.name,
                  $sformatf("lane0 got %h want %h", {hi_flat[31:0], lo_flat[31:0]}, e.hand));
          if (e.lat_en)
            check(cyc - e.acc_cyc == LAT, {e.name, "_lat"}, $sformatf("latency %0d want %0d", cyc - e.acc_cyc, LAT));
`ifdef SIMD_ALU_OVF_FLAG_EN
          check(ovf === e.ovf, {e.name, "_ovf"}, $sformatf("ovf got %h want %h", ovf, e.ovf));
`endif
        end
      end
    end
  end

  initial begin
    logic [LANES*WIDTH-1:0] snap_lo, snap_hi;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; acc_clr = 1'b0;
    a_flat = '0; b_flat = '0;
    for (int i = 0; i < LANES; i++) begin acc_m[i] = 0; ovf_m[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    check(out_valid === 1'b0, "rst_out_valid", $sformatf("got %b want 0", out_valid));
    check(lo_flat === '0 && hi_flat === '0, "rst_data", $sformatf("lo0=%h hi0=%h want 0", lo_flat[31:0], hi_flat[31:0]));
    rst = 1'b0;
    @(negedge clk);
    check(in_ready === 1'b1, "rst_in_ready", $sformatf("got %b want 1", in_ready));
    @(posedge clk); #1;

    send(2'b00, 0, -5, 7, 1, 64'd2, 0, "add");
    send(2'b10, 0, -5, 7, 1, 64'hFFFF_FFFF_FFFF_FFF4, 0, "sub");
    send(2'b00, 0, 32'h7FFF_FFFF, 1, 1, 64'h0000_0000_8000_0000, 0, "add_max");
    repeat (3) @(posedge clk); #1;
    send(2'b01, 0, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000, 1, "mul_min");
    repeat (3) @(posedge clk); #1;
    send(2'b01, 0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1, 64'hFFFF_FFFF_8000_0001, 1, "mul_neg");

    send(2'b11, 1, 3, 4, 1, 64'd12, 0, "mac1");
    send(2'b11, 0, 2, 5, 1, 64'd22, 0, "mac2");
    send(2'b11, 0, -1, 6, 1, 64'd16, 0, "mac3");
    send(2'b10, 1, 10, 3, 1, 64'd7, 0, "sub_clr");
    send(2'b11, 0, 1, 1, 1, 64'd1, 0, "mac_after_clr");
    drain();

    fork
      begin
        for (int k = 0; k < 8; k++)
          send(2'(k % 4), k == 0, 32'(k*3 + 1), 32'(5 - k), 0, 64'd0, 0, "bp");
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          if (j == 0) begin snap_lo = lo_flat; snap_hi = hi_flat; end
          check(in_ready === 1'b0 && out_valid === 1'b1, "bp_stall",
                $sformatf("in_ready=%b out_valid=%b want 0/1", in_ready, out_valid));
          check(lo_flat === snap_lo && hi_flat === snap_hi, "bp_stable",
                $sformatf("lo0=%h hi0=%h want %h %h", lo_flat[31:0], hi_flat[31:0], snap_lo[31:0], snap_hi[31:0]));
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    @(posedge clk); #1;
    send(2'b00, 0, 1, 2, 0, 64'd0, 0, "inflight1");
    send(2'b11, 0, 3, 4, 0, 64'd0, 0, "inflight2");
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < LANES; i++) begin acc_m[i] = 0; ovf_m[i] = 1'b0; end
    #1;
    check(out_valid === 1'b0 && lo_flat === '0 && hi_flat === '0, "midrst_flush",
          $sformatf("out_valid=%b lo0=%h hi0=%h want 0", out_valid, lo_flat[31:0], hi_flat[31:0]));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(2'b11, 0, 2, 3, 1, 64'd6, 0, "mac_post_rst");
    drain();

`ifdef SIMD_ALU_OVF_FLAG_EN
    @(posedge clk); #1;
    send(2'b11, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 64'h3FFF_FFFF_0000_0001, 0, "ovf1");
    send(2'b11, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 64'h7FFF_FFFE_0000_0002, 0, "ovf2");
    send(2'b11, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 64'hBFFF_FFFD_0000_0003, 0, "ovf3");
    send(2'b11, 0, 1, 1, 1, 64'hBFFF_FFFD_0000_0004, 0, "ovf_sticky");
    send(2'b00, 1, 0, 0, 1, 64'd0, 0, "ovf_clr");
    drain();
    check(ovf[0] === 1'b0, "ovf_cleared", $sformatf("ovf0=%b want 0", ovf[0]));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
